// File: rtl/glb_pcfg_pkg.sv
// Shared types for the GLB parallel-config controller: FSM states, bitstream
// word layout and the bank word stride.
package glb_pcfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcfg_state_t;

  typedef struct packed {
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
  } pcfg_word_t;

  localparam int WORD_STRIDE = 8;

endpackage

// File: rtl/glb_pcfg_fifo.sv
// First-word-fall-through FIFO holding bank read returns until the output
// stage is free of global config traffic.
module glb_pcfg_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/glb_pcfg_controller.sv
// Streams a bitstream of {addr, data} words from the GLB bank onto the masked
// CGRA config columns; global config traffic always owns the outputs.
module glb_pcfg_controller
  import glb_pcfg_pkg::*;
#(
  parameter int CGRA_PER_GLB        = 4,
  parameter int CGRA_CFG_ADDR_WIDTH = 32,
  parameter int CGRA_CFG_DATA_WIDTH = 32,
  parameter int BANK_DATA_WIDTH     = 64,
  parameter int GLB_ADDR_WIDTH      = 22,
  parameter int NUM_CFG_WIDTH       = 16,
  parameter int MAX_OUTSTANDING     = 4
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  pcfg_start_pulse,
  input  logic [GLB_ADDR_WIDTH-1:0]                             cfg_start_addr,
  input  logic [NUM_CFG_WIDTH-1:0]                              cfg_num_cfg,
  input  logic [CGRA_PER_GLB-1:0]                               cfg_column_mask,
  output logic                                                  rd_req,
  output logic [GLB_ADDR_WIDTH-1:0]                             rd_addr,
  input  logic [BANK_DATA_WIDTH-1:0]                            rd_data,
  input  logic                                                  rd_data_valid,
  input  logic                                                  glb_cfg_wr_en,
  input  logic                                                  glb_cfg_rd_en,
  input  logic [CGRA_CFG_ADDR_WIDTH-1:0]                        glb_cfg_addr,
  input  logic [CGRA_CFG_DATA_WIDTH-1:0]                        glb_cfg_data,
  output logic [CGRA_PER_GLB-1:0]                               cgra_cfg_wr_en,
  output logic [CGRA_PER_GLB-1:0]                               cgra_cfg_rd_en,
  output logic [CGRA_PER_GLB-1:0][CGRA_CFG_ADDR_WIDTH-1:0]      cgra_cfg_addr,
  output logic [CGRA_PER_GLB-1:0][CGRA_CFG_DATA_WIDTH-1:0]      cgra_cfg_data,
  output logic                                                  pcfg_busy,
  output logic                                                  pcfg_done_pulse
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  pcfg_state_t                state, state_nxt;
  logic [GLB_ADDR_WIDTH-1:0]  addr_q;
  logic [NUM_CFG_WIDTH-1:0]   num_q, issued_q;
  logic [CGRA_PER_GLB-1:0]    mask_q;
  logic [OW-1:0]              outst_q, fifo_count;
  logic [BANK_DATA_WIDTH-1:0] fifo_dout;
  logic fifo_empty, fifo_push, fifo_pop;
  logic glb_act, issue, all_issued, drained, start;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^cfg_start_addr[2:0];

  assign glb_act    = glb_cfg_wr_en | glb_cfg_rd_en;
  assign start      = (state == IDLE) && pcfg_start_pulse;
  assign all_issued = (issued_q == num_q);
  // Credits cover both reads in flight and words parked in the FIFO.
  assign issue      = (state == RUN) && !all_issued && ((fifo_count + outst_q) < MAX_OUT);
  assign fifo_push  = (state == RUN) && rd_data_valid;
  assign fifo_pop   = !glb_act && !fifo_empty;
  // The final word is popped into the output stage as the FIFO drains, so
  // DONE lands the cycle after that word is visible.
  assign drained    = all_issued && (outst_q == '0) && fifo_empty;

  glb_pcfg_fifo #(
    .WIDTH (BANK_DATA_WIDTH),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (OW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (rd_data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pcfg_start_pulse) state_nxt = (cfg_num_cfg == '0) ? DONE : RUN;
      RUN:     if (drained) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      mask_q   <= '0;
      outst_q  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_q   <= {cfg_start_addr[GLB_ADDR_WIDTH-1:3], 3'b000};
        num_q    <= cfg_num_cfg;
        mask_q   <= cfg_column_mask;
        issued_q <= '0;
        outst_q  <= '0;
      end else begin
        if (issue) begin
          addr_q   <= addr_q + GLB_ADDR_WIDTH'(WORD_STRIDE);
          issued_q <= issued_q + 1'b1;
        end
        case ({issue, fifo_push})
          2'b10:   outst_q <= outst_q + 1'b1;
          2'b01:   outst_q <= outst_q - 1'b1;
          default: outst_q <= outst_q;
        endcase
      end
    end
  end

  // Registered output stage: global traffic first, then stream words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cgra_cfg_wr_en <= '0;
      cgra_cfg_rd_en <= '0;
      cgra_cfg_addr  <= '0;
      cgra_cfg_data  <= '0;
    end else begin
      for (int c = 0; c < CGRA_PER_GLB; c++) begin
        if (glb_act) begin
          cgra_cfg_wr_en[c] <= glb_cfg_wr_en;
          cgra_cfg_rd_en[c] <= glb_cfg_rd_en;
          cgra_cfg_addr[c]  <= glb_cfg_addr;
          cgra_cfg_data[c]  <= glb_cfg_data;
        end else if (fifo_pop) begin
          cgra_cfg_wr_en[c] <= mask_q[c];
          cgra_cfg_rd_en[c] <= 1'b0;
          cgra_cfg_addr[c]  <= fifo_dout[BANK_DATA_WIDTH-1 -: CGRA_CFG_ADDR_WIDTH];
          cgra_cfg_data[c]  <= fifo_dout[CGRA_CFG_DATA_WIDTH-1:0];
        end else begin
          cgra_cfg_wr_en[c] <= 1'b0;
          cgra_cfg_rd_en[c] <= 1'b0;
        end
      end
    end
  end

  assign rd_req          = issue;
  assign rd_addr         = addr_q;
  assign pcfg_busy       = (state != IDLE);
  assign pcfg_done_pulse = (state == DONE);

endmodule
